// File: rtl/dm_pkg.sv
// dm_pkg: data-memory access types shared by ctrl and the LSU.
// DM type codes, LSU FSM states and response cause codes.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISAL   = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  function automatic logic dm_is_half(input logic [2:0] t);
    return (t == DM_HALF) || (t == DM_HALF_U);
  endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Core-side request/response and data-memory bus interfaces
// of the load/store unit.
interface lsu_core_if;
  logic        in_valid;
  logic        in_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  dm_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [1:0]  resp_cause;
  logic        stall;

  modport master (
    output in_valid, mem_read, mem_write,
    output dm_type, addr, wdata,
    input  in_ready, resp_valid, resp_data,
    input  resp_err, resp_cause, stall
  );

  modport slave (
    input  in_valid, mem_read, mem_write,
    input  dm_type, addr, wdata,
    output in_ready, resp_valid, resp_data,
    output resp_err, resp_cause, stall
  );
endinterface

interface dmem_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: byte-lane steering for stores and load extract/extend.
// Purely combinational so a cache path can reuse it.
module lsu_lane
  import dm_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_sh;
  logic        w_sgn;

  assign w_sh  = i_rdata >> {i_off, 3'b000};
  assign w_sgn = (i_type == DM_HALF) || (i_type == DM_BYTE);

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    o_ldata = 32'h0;
    case (i_type)
      DM_WORD: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_ldata = w_sh;
      end
      DM_HALF, DM_HALF_U: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
        o_ldata = {{16{w_sgn & w_sh[15]}}, w_sh[15:0]};
      end
      DM_BYTE, DM_BYTE_U: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_ldata = {{24{w_sgn & w_sh[7]}}, w_sh[7:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: single-outstanding load/store unit between EX and
// the data-memory req/ack bus, with alignment and timeout checks.
module lsu_mem_if
  import dm_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic        clk,
  input logic        rstn,
  lsu_core_if.slave  core,
  dmem_bus_if.master bus
);

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic [1:0]  r_off;
  logic [2:0]  r_type;
  logic [1:0]  r_cause;
  logic [7:0]  r_cnt;

  logic        w_idle;
  logic        w_acc;
  logic        w_bad;
  logic        w_mis;
  logic        w_to;
  logic [2:0]  w_type;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wrep;
  logic [31:0] w_ldata;

  assign w_idle = r_state == ST_IDLE;
  assign w_acc  = core.in_valid & w_idle
                & (core.mem_read | core.mem_write);
  assign w_bad  = (core.dm_type > DM_BYTE_U)
                | (core.mem_read & core.mem_write);
  assign w_mis  = ((core.dm_type == DM_WORD)
                   & (core.addr[1:0] != 2'b00))
                | (dm_is_half(core.dm_type) & core.addr[0]);
  // Ack in the final REQ cycle wins over the timeout.
  assign w_to   = (r_cnt == LP_LAST) & ~bus.bus_ack;

  // Lane sees the request at accept and the held access in REQ.
  assign w_type = w_idle ? core.dm_type : r_type;
  assign w_off  = w_idle ? core.addr[1:0] : r_off;

  lsu_lane u_lane (
    .i_type  (w_type),
    .i_off   (w_off),
    .i_wdata (core.wdata),
    .i_rdata (bus.bus_rdata),
    .o_be    (w_be),
    .o_wdata (w_wrep),
    .o_ldata (w_ldata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc)
          w_next = (w_bad | w_mis) ? ST_RESP : ST_REQ;
      end
      ST_REQ: begin
        if (bus.bus_ack | w_to) w_next = ST_RESP;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    core.in_ready   = w_idle;
    core.stall      = w_acc | (r_state == ST_REQ);
    core.resp_valid = r_state == ST_RESP;
    core.resp_err   = (r_state == ST_RESP)
                    & (r_cause != CAUSE_NONE);
    core.resp_cause = (r_state == ST_RESP) ? r_cause
                                           : CAUSE_NONE;
    core.resp_data  = (r_state == ST_RESP) ? r_rdata : 32'h0;
    bus.bus_req     = r_state == ST_REQ;
  end

  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_off   <= '0;
      r_type  <= '0;
      r_cause <= CAUSE_NONE;
      r_cnt   <= '0;
    end else if (w_acc) begin
      r_off   <= core.addr[1:0];
      r_type  <= core.dm_type;
      r_cnt   <= '0;
      r_rdata <= '0;
      if (w_bad) begin
        r_cause <= CAUSE_ILLEGAL;
      end else if (w_mis) begin
        r_cause <= CAUSE_MISAL;
      end else begin
        r_cause <= CAUSE_NONE;
        r_addr  <= {core.addr[31:2], 2'b00};
        r_be    <= w_be;
        r_we    <= core.mem_write;
        r_wdata <= w_wrep;
      end
    end else if (r_state == ST_REQ) begin
      if (bus.bus_ack) begin
        if (!r_we) r_rdata <= w_ldata;
      end else if (w_to) begin
        r_cause <= CAUSE_TIMEOUT;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: randomized scoreboard bench for lsu_mem_if
// against a byte-level memory reference model.
module tb_lsu_mem_if;
  import dm_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [1:0]  cause;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          len;
    int          delay;
  } bus_t;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  int   cyc;

  rsp_t        sb_q[$];
  bus_t        bq[$];
  logic [31:0] mem[16];
  logic [31:0] ref_mem[16];

  lsu_core_if core ();
  dmem_bus_if bus ();

  lsu_mem_if #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .core (core),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int dm_size(input logic [2:0] t);
    if (t == DM_WORD) return 4;
    if (t == DM_HALF || t == DM_HALF_U) return 2;
    return 1;
  endfunction

  // Issue one access at a negedge and predict its outcome.
  task automatic issue(input logic rd, input logic wr,
                       input logic [2:0] t,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input int dly);
    rsp_t        r;
    bus_t        b;
    int          n;
    int          off;
    int          idx;
    int          k;
    logic [31:0] w;
    logic [31:0] mask;
    k = 0;
    while (!core.in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!core.in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_wait: got 0 expected 1");
      return;
    end
    core.in_valid  = 1'b1;
    core.mem_read  = rd;
    core.mem_write = wr;
    core.dm_type   = t;
    core.addr      = a;
    core.wdata     = wd;
    n   = dm_size(t);
    off = int'(a[1:0]);
    idx = int'(a[5:2]);
    r.cyc   = cyc;
    r.data  = 32'h0;
    r.err   = 1'b0;
    r.cause = 2'b00;
    if (t > 3'd4 || (rd && wr)) begin
      r.err   = 1'b1;
      r.cause = 2'b10;
      r.cyc   = r.cyc + 1;
    end else if (off % n != 0) begin
      r.err   = 1'b1;
      r.cause = 2'b01;
      r.cyc   = r.cyc + 1;
    end else begin
      b.addr  = {a[31:2], 2'b00};
      b.be    = 4'b0000;
      b.wdata = 32'h0;
      for (int i = 0; i < n; i++) b.be[off+i] = 1'b1;
      for (int i = 0; i < 4; i++)
        b.wdata[8*i +: 8] = wd[8*(i%n) +: 8];
      b.we    = wr;
      b.delay = dly;
      b.len   = (dly == 0) ? TO : dly;
      bq.push_back(b);
      if (dly == 0) begin
        r.err   = 1'b1;
        r.cause = 2'b11;
        r.cyc   = r.cyc + TO + 1;
      end else begin
        r.cyc = r.cyc + dly + 1;
        if (wr) begin
          for (int i = 0; i < n; i++)
            ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
        end else begin
          w = ref_mem[idx] >> (8 * off);
          if (n == 4) begin
            r.data = w;
          end else begin
            mask   = (n == 2) ? 32'h0000FFFF : 32'h000000FF;
            r.data = w & mask;
            if ((t == DM_HALF || t == DM_BYTE) && w[8*n-1])
              r.data = r.data | ~mask;
          end
        end
      end
    end
    sb_q.push_back(r);
    #1;
    chk("stall_accept", 64'(core.stall), 64'd1);
    @(negedge clk);
    core.in_valid = 1'b0;
    core.wdata    = $urandom;
  endtask

  // Memory responder: acks after the delay chosen at issue time.
  initial begin
    int   cnt;
    int   ix;
    bus_t cur;
    cnt           = 0;
    cur.delay     = 1;
    cur.len       = 1;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        cnt         = 0;
        bus.bus_ack = 1'b0;
        continue;
      end
      if (bus.bus_req) begin
        if (cnt == 0) begin
          if (bq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bus_unexpected: got bus_req=1 expected 0");
            cur.delay = 1;
            cur.len   = 1;
          end else begin
            cur = bq.pop_front();
            chk("bus_fields",
                64'({bus.bus_addr, bus.bus_be, bus.bus_we}),
                64'({cur.addr, cur.be, cur.we}));
            if (cur.we)
              chk("bus_wdata", 64'(bus.bus_wdata),
                  64'(cur.wdata));
            chk("stall_req", 64'(core.stall), 64'd1);
          end
        end
        cnt++;
        if (cnt == cur.delay) begin
          ix = int'(bus.bus_addr[5:2]);
          if (bus.bus_we) begin
            for (int i = 0; i < 4; i++)
              if (bus.bus_be[i])
                mem[ix][8*i +: 8] = bus.bus_wdata[8*i +: 8];
          end
          bus.bus_rdata = mem[ix];
          bus.bus_ack   = 1'b1;
        end else begin
          bus.bus_rdata = $urandom;
          bus.bus_ack   = 1'b0;
        end
      end else begin
        bus.bus_ack = 1'b0;
        if (cnt != 0) begin
          chk("bus_req_len", 64'(cnt), 64'(cur.len));
          cnt = 0;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      #1;
      if (rstn && core.resp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected: got resp_valid=1 expected 0");
        end else begin
          r = sb_q.pop_front();
          chk("resp",
              64'({core.resp_data, core.resp_err,
                   core.resp_cause}),
              64'({r.data, r.err, r.cause}));
          chk("resp_cycle", 64'(cyc), 64'(r.cyc));
          chk("stall_resp", 64'(core.stall), 64'd0);
        end
      end
    end
  end

  initial begin
    int          k;
    int          rw;
    logic [2:0]  t;
    logic [31:0] a;
    int          dly;
    checks         = 0;
    failures       = 0;
    rstn           = 1'b0;
    core.in_valid  = 1'b0;
    core.mem_read  = 1'b0;
    core.mem_write = 1'b0;
    core.dm_type   = 3'b000;
    core.addr      = 32'h0;
    core.wdata     = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h80F17F82;
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(core.in_ready), 64'd1);
    chk("rst_core_outs",
        64'({core.stall, core.resp_valid, core.resp_data,
             core.resp_err, core.resp_cause}), 64'd0);
    chk("rst_bus_outs",
        64'({bus.bus_req, bus.bus_we, bus.bus_be,
             bus.bus_addr}), 64'd0);
    chk("rst_bus_wdata", 64'(bus.bus_wdata), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    issue(1'b0, 1'b1, DM_WORD, 32'h104, 32'hDEADBEEF, 1);
    issue(1'b0, 1'b1, DM_BYTE, 32'h107, 32'h000000A5, 2);
    issue(1'b1, 1'b0, DM_BYTE,   32'h100, 32'h0, 1);
    issue(1'b1, 1'b0, DM_BYTE_U, 32'h100, 32'h0, 2);
    issue(1'b1, 1'b0, DM_HALF,   32'h102, 32'h0, 3);
    issue(1'b1, 1'b0, DM_HALF_U, 32'h102, 32'h0, 1);
    issue(1'b1, 1'b0, DM_WORD,   32'h104, 32'h0, 1);
    issue(1'b1, 1'b0, DM_WORD,   32'h101, 32'h0, 1);
    issue(1'b1, 1'b0, 3'b101,    32'h100, 32'h0, 1);
    issue(1'b1, 1'b1, DM_WORD,   32'h100, 32'h0, 1);
    issue(1'b0, 1'b1, DM_HALF,   32'h103, 32'h1234, 1);

    // in_valid with neither flag set is dropped.
    k = 0;
    while (!core.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    core.in_valid = 1'b1;
    core.mem_read = 1'b0;
    core.mem_write = 1'b0;
    #1;
    chk("drop_stall", 64'(core.stall), 64'd0);
    @(negedge clk);
    core.in_valid = 1'b0;
    #1;
    chk("drop_in_ready", 64'(core.in_ready), 64'd1);
    @(negedge clk);

    issue(1'b1, 1'b0, DM_WORD, 32'h10C, 32'h0, 0);
    issue(1'b0, 1'b1, DM_WORD, 32'h110, 32'h55AA1234, 0);
    issue(1'b1, 1'b0, DM_WORD, 32'h10C, 32'h0, TO);
    issue(1'b0, 1'b1, DM_HALF, 32'h112, 32'hCAFE, TO);

    // Reset in the second REQ cycle: access is lost.
    issue(1'b1, 1'b0, DM_WORD, 32'h108, 32'h0, 0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_bus_req", 64'(bus.bus_req), 64'd0);
    chk("rst_mid_in_ready", 64'(core.in_ready), 64'd1);
    sb_q.delete();
    bq.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    issue(1'b1, 1'b0, DM_WORD, 32'h108, 32'h0, 1);

    for (int it = 0; it < 200; it++) begin
      rw = int'($urandom_range(0, 9));
      k  = int'($urandom_range(0, 15));
      t  = (k < 14) ? 3'(k % 5) : 3'(5 + k % 3);
      a  = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0) begin
        if (t == DM_WORD) a[1:0] = 2'b00;
        else if (dm_is_half(t)) a[0] = 1'b0;
      end
      dly = ($urandom_range(0, 9) == 0)
          ? 0 : int'($urandom_range(1, TO));
      issue(rw == 0 || rw < 5, rw == 0 || rw >= 5,
            t, a, $urandom, dly);
    end

    for (int i = 0; i < 16; i++)
      issue(1'b1, 1'b0, DM_WORD, 32'h100 + 32'(4 * i), 32'h0, 1);

    k = 0;
    while ((sb_q.size() != 0 || bq.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("drain_resp", 64'(sb_q.size()), 64'd0);
    chk("drain_bus", 64'(bq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
